// File: rtl/freq_synth_pkg.sv
// Shared constants and FSM encoding for the frequency synthesiser.
package freq_synth_pkg;

  localparam int ACC_W     = 32;
  localparam int DIV_STEPS = 32;
  localparam int STEP_W    = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PEND
  } state_e;

endpackage

// File: rtl/serial_div_u32.sv
// 32-step restoring divider producing floor(dividend * 2^32 / divisor).
// The dividend must be smaller than the divisor.
module serial_div_u32
  import freq_synth_pkg::*;
#(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [ACC_W-1:0] quotient_o,
  output logic             done_o
);

  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [DIV_W:0]    rem_sh;
  logic [ACC_W-1:0]  quot_q, quot_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;

  assign rem_sh = {rem_q, 1'b0};

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    step_d = step_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = dividend_i;
      quot_d = '0;
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Remainder stays below the divisor, so it always fits back into DIV_W bits.
      if (rem_sh >= {1'b0, divisor_i}) begin
        rem_d  = DIV_W'(rem_sh - {1'b0, divisor_i});
        quot_d = {quot_q[ACC_W-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[DIV_W-1:0];
        quot_d = {quot_q[ACC_W-2:0], 1'b0};
      end
      step_d = step_q + STEP_W'(1);
      if (step_q == STEP_W'(DIV_STEPS - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign done_o     = busy_q && (step_q == STEP_W'(DIV_STEPS - 1));
  assign quotient_o = quot_q;

endmodule

// File: rtl/freq_synth.sv
// Square-wave generator: a requested frequency becomes a phase increment that is
// swapped into the accumulator only at a wrap, so the output never glitches.
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter logic [25:0] CLK_FS = 26'd50_000_000,
  parameter int          FREQ_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [FREQ_W-1:0] cfg_freq,
  output logic              wave_out,
  output logic              rise_tick,
  output logic [FREQ_W-1:0] cur_freq,
  output logic [ACC_W-1:0]  phase_inc
);

  localparam int          DIV_W  = 26;
  localparam int unsigned HALF_I = 32'(CLK_FS >> 1);
  // Saturate when Nyquist exceeds the word range: no request can then exceed it.
  localparam logic [FREQ_W-1:0] HALF_FS =
    (longint'(HALF_I) >= (longint'(1) << FREQ_W)) ? {FREQ_W{1'b1}} : FREQ_W'(HALF_I);

  state_e            state_q;
  logic              ready_q, rise_q;
  logic [FREQ_W-1:0] freq_eff_q, freq_eff_d, cur_freq_q;
  logic [ACC_W-1:0]  acc_q, inc_q, quot;
  logic [ACC_W:0]    sum;
  logic              accept, apply, div_done;

  assign freq_eff_d = (cfg_freq > HALF_FS) ? HALF_FS : cfg_freq;
  assign accept     = cfg_valid && ready_q;
  assign sum        = {1'b0, acc_q} + {1'b0, inc_q};
  assign apply      = (state_q == PEND) && (sum[ACC_W] || (inc_q == '0));

  serial_div_u32 #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .dividend_i(DIV_W'(freq_eff_d)),
    .divisor_i (CLK_FS),
    .quotient_o(quot),
    .done_o    (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      freq_eff_q <= '0;
      cur_freq_q <= '0;
      inc_q      <= '0;
      acc_q      <= '0;
      rise_q     <= 1'b0;
    end else begin
      // The add in the apply cycle still uses the old increment.
      acc_q  <= sum[ACC_W-1:0];
      rise_q <= sum[ACC_W];
      case (state_q)
        IDLE: if (accept) begin
          freq_eff_q <= freq_eff_d;
          ready_q    <= 1'b0;
          state_q    <= DIV;
        end
        DIV: if (div_done) state_q <= PEND;
        PEND: if (apply) begin
          inc_q      <= quot;
          cur_freq_q <= freq_eff_q;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready = ready_q;
  assign wave_out  = acc_q[ACC_W-1];
  assign rise_tick = rise_q;
  assign cur_freq  = cur_freq_q;
  assign phase_inc = inc_q;

endmodule

// File: tb/tb_freq_synth.sv
// Randomised bench for freq_synth: two instances (50 MHz and 1 MHz clock settings)
// share one stimulus and are compared each cycle against an arithmetic model.
module tb_freq_synth;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic [19:0] cfg_freq = '0;

  logic [1:0] rdy, wav, rise;
  logic [1:0][19:0] cur;
  logic [1:0][31:0] inc;

  int n_checks = 0;
  int n_err = 0;
  bit model_on = 0;

  always #5 clk = ~clk;

  freq_synth dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]),
    .cfg_freq(cfg_freq), .wave_out(wav[0]), .rise_tick(rise[0]),
    .cur_freq(cur[0]), .phase_inc(inc[0])
  );

  freq_synth #(.CLK_FS(26'd1_000_000), .FREQ_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]),
    .cfg_freq(cfg_freq), .wave_out(wav[1]), .rise_tick(rise[1]),
    .cur_freq(cur[1]), .phase_inc(inc[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: request latency counted in edges, increment from plain arithmetic.
  longint fs [2] = '{50_000_000, 1_000_000};
  longint m_acc [2], m_inc [2], m_cur [2], m_f [2], m_q [2];
  int     m_age [2];
  bit     m_pend [2], m_rise [2];

  always @(posedge clk) begin
    longint s;
    longint f;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_inc[i] = 0; m_cur[i] = 0; m_f[i] = 0; m_q[i] = 0;
        m_age[i] = 0; m_pend[i] = 0; m_rise[i] = 0;
      end else begin
        s = m_acc[i] + m_inc[i];
        if (m_pend[i]) begin
          m_age[i]++;
          if (m_age[i] >= 33 && (s >= 64'h1_0000_0000 || m_inc[i] == 0)) begin
            m_inc[i] = m_q[i];
            m_cur[i] = m_f[i];
            m_pend[i] = 0;
          end
        end else if (cfg_valid) begin
          f = longint'(cfg_freq);
          if (f > fs[i] / 2) f = fs[i] / 2;
          m_f[i] = f;
          m_q[i] = (f << 32) / fs[i];
          m_pend[i] = 1;
          m_age[i] = 0;
        end
        m_rise[i] = (s >= 64'h1_0000_0000);
        m_acc[i] = s % 64'h1_0000_0000;
      end
    end
    model_on = 1;
  end

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cfg_ready[%0d]", i), 64'(rdy[i]), 64'(!m_pend[i]));
        check($sformatf("wave_out[%0d]", i), 64'(wav[i]), 64'(m_acc[i] >= 64'h8000_0000));
        check($sformatf("rise_tick[%0d]", i), 64'(rise[i]), 64'(m_rise[i]));
        check($sformatf("cur_freq[%0d]", i), 64'(cur[i]), m_cur[i]);
        check($sformatf("phase_inc[%0d]", i), 64'(inc[i]), m_inc[i]);
      end
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (rdy !== 2'b11 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (rdy !== 2'b11) check("ready_timeout", 64'(rdy), 64'd3);
  endtask

  task automatic request(input logic [19:0] f);
    @(negedge clk); cfg_valid = 1'b1; cfg_freq = f;
    @(negedge clk); cfg_valid = 1'b0; cfg_freq = 20'($urandom);
  endtask

  initial begin
    logic [31:0] old_inc [2];
    bit seen [2];
    int last, nint, nrise;
    logic prev;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #2;
    check("rst_ready", 64'(rdy), 64'd3);
    check("rst_wave", 64'(wav), 64'd0);
    check("rst_rise", 64'(rise), 64'd0);
    check("rst_cur_a", 64'(cur[0]), 64'd0);
    check("rst_inc_a", 64'(inc[0]), 64'd0);

    // 1 MHz request: instance b clamps to its Nyquist limit.
    @(negedge clk); cfg_valid = 1'b1; cfg_freq = 20'd1_000_000;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("ready_low_after_accept", 64'(rdy), 64'd0);
    repeat (32) @(posedge clk);
    #1;
    check("inc_before_e33_a", 64'(inc[0]), 64'd0);
    @(posedge clk); #1;
    check("inc_e33_a", 64'(inc[0]), 64'd85_899_345);
    check("cur_e33_a", 64'(cur[0]), 64'd1_000_000);
    check("inc_e33_b", 64'(inc[1]), 64'h8000_0000);
    check("cur_e33_b", 64'(cur[1]), 64'd500_000);
    @(posedge clk); #1;
    check("ready_after_apply", 64'(rdy), 64'd3);
    prev = wav[1];
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("toggle_b", 64'(wav[1]), 64'(!prev));
      prev = wav[1];
    end
    last = -1; nint = 0;
    for (int k = 0; k < 400 && nint < 3; k++) begin
      @(posedge clk); #1;
      if (rise[0]) begin
        if (last >= 0) begin
          check("period_a", 64'(k - last), 64'd50);
          nint++;
        end
        last = k;
      end
    end
    if (nint < 3) check("period_a_count", 64'(nint), 64'd3);

    // Slow down: the swap must coincide with a wrap.
    old_inc[0] = inc[0]; old_inc[1] = inc[1];
    seen[0] = 0; seen[1] = 0;
    request(20'd10_000);
    for (int k = 0; k < 300 && !(seen[0] && seen[1]); k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (!seen[i] && inc[i] != old_inc[i]) begin
          check($sformatf("apply_on_rise[%0d]", i), 64'(rise[i]), 64'd1);
          seen[i] = 1;
        end
    end
    check("apply_seen", 64'({seen[1], seen[0]}), 64'd3);
    wait_ready(300);

    request(20'd0);
    wait_ready(6000);
    @(posedge clk); #1;
    check("zero_wave", 64'(wav), 64'd0);
    nrise = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (rise != 2'b00) nrise++;
    end
    check("zero_no_rise", 64'(nrise), 64'd0);

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 5) == 0) request(20'd0);
      else request(20'($urandom_range(100_000, 1_048_575)));
      wait_ready(1000);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end

    for (int k = 0; k < 600; k++) begin
      @(negedge clk); cfg_valid = 1'b1; cfg_freq = 20'($urandom_range(100_000, 1_048_575));
    end
    @(negedge clk); cfg_valid = 1'b0;
    @(posedge clk); #1;
    wait_ready(1000);

    // Reset in the middle of a division discards the request.
    request(20'd700_000);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #2;
    check("mid_rst_ready", 64'(rdy), 64'd3);
    check("mid_rst_inc", 64'(inc), 64'd0);
    check("mid_rst_cur", 64'(cur), 64'd0);
    check("mid_rst_wave", 64'({wav, rise}), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("mid_rst_never_applied", 64'(inc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
